sme_host_driver: RTL

- Host-side driver for the string-matching engine: the transmitter end of its chardata/isstring/ispattern interface and the receiver of its valid/match/match_index result.
- A host preloads a string buffer and a pattern buffer, then issues start.
- The block serialises the characters onto the engine interface, waits for valid and latches the result.
- It presents the result to the host with a done pulse and a timeout flag.

---
 rtl/sme_host_driver.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sme_host_driver.sv
// Host-side driver for the string-matching engine: buffers string/pattern bytes, bursts them
// to the engine, then waits (bounded) for valid and presents the latched result with a done pulse.
module sme_host_driver #(
  parameter int STR_MAX     = 32,
  parameter int PAT_MAX     = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic [5:0] str_len,
  input  logic [3:0] pat_len,
  input  logic       send_str,
  output logic       busy,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       timeout,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index
);

  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT, DONE} state_t;

  state_t        state;
  logic [7:0]    sbuf [STR_MAX];
  logic [7:0]    pbuf [PAT_MAX];
  logic [5:0]    slen_q;
  logic [3:0]    plen_q;
  logic [5:0]    idx;
  logic [TW-1:0] wcnt;
  logic          str_loaded;
  logic          eff_send;
  logic          start_ok;

  // The engine must have a string before it can match, so the first run always sends one.
  assign eff_send = send_str | ~str_loaded;
  assign start_ok = start && (pat_len != 4'd0) && (int'(pat_len) <= PAT_MAX) &&
                    (!eff_send || ((str_len != 6'd0) && (int'(str_len) <= STR_MAX)));

  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) begin
      if (!wr_sel) begin
        if (int'(wr_addr) < STR_MAX) sbuf[wr_addr[SAW-1:0]] <= wr_data;
      end else begin
        pbuf[wr_addr[PAW-1:0]] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      slen_q     <= '0;
      plen_q     <= '0;
      idx        <= '0;
      wcnt       <= '0;
      str_loaded <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      res_match  <= 1'b0;
      res_index  <= '0;
      timeout    <= 1'b0;
      chardata   <= 8'h00;
      isstring   <= 1'b0;
      ispattern  <= 1'b0;
    end else begin
      isstring  <= 1'b0;
      ispattern <= 1'b0;
      chardata  <= 8'h00;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            slen_q <= str_len;
            plen_q <= pat_len;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= eff_send ? SEND_STR : SEND_PAT;
          end
        end
        SEND_STR: begin
          isstring   <= 1'b1;
          chardata   <= sbuf[idx[SAW-1:0]];
          str_loaded <= 1'b1;
          if (idx == slen_q - 6'd1) begin
            idx   <= '0;
            state <= SEND_PAT;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        SEND_PAT: begin
          ispattern <= 1'b1;
          chardata  <= pbuf[idx[PAW-1:0]];
          if (idx == {2'b00, plen_q - 4'd1}) begin
            wcnt  <= '0;
            state <= WAIT;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        WAIT: begin
          // A valid on the terminal-count cycle still wins over the timeout.
          if (valid) begin
            res_match <= match;
            res_index <= match_index;
            timeout   <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (wcnt == T_LAST) begin
            res_match <= 1'b0;
            res_index <= '0;
            timeout   <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            wcnt <= wcnt + T_ONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
